lc3_mem_arbiter: RTL

//  Shares the single-port LC-3 main memory between two requesters: port 0 (CPU
//  MAR/MDR path: fetch, load, store) and port 1 (host loader/debug port).

---
 rtl/lc3_mem_arbiter_if.sv | 36 +++
 rtl/lc3_mem_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between the two LC-3 memory requesters, the arbiter and the memory macro.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface lc3_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req0, we0, ack0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0, rdata0;
   logic              req1, we1, ack1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1, rdata1;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic [1:0]        grant;
   logic              busy;

   modport master (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_rdata,
      output rdata0, ack0, rdata1, ack1,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output grant, busy
   );

   modport slave (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_rdata,
      input  rdata0, ack0, rdata1, ack1,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  grant, busy
   );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter sharing the single-port LC-3 memory between the CPU (port 0)
// and the host loader (port 1); one access in flight, fixed memory read latency.
module lc3_mem_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int MEM_LATENCY = 2
) (
   input logic               clk,
   input logic               reset,
   lc3_mem_arbiter_if.master bus
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t            state, next_state;
   logic              last_grant;
   logic              owner;
   logic              we_q;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;
   logic              any_req;
   logic              pick;

   // On a tie the port that did not win last time gets the memory.
   always_comb begin
      any_req = bus.req0 | bus.req1;
      pick    = 1'b0;
      if (bus.req0 && bus.req1) pick = ~last_grant;
      else if (bus.req1)        pick = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_req) next_state = ISSUE;
         ISSUE:   next_state = we_q ? ACK : WAIT;
         WAIT:    if (cnt == '0) next_state = ACK;
         ACK:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request fields are latched at grant, so later requester changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         we_q       <= 1'b0;
         cnt        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner      <= pick;
                  last_grant <= pick;
                  we_q       <= pick ? bus.we1    : bus.we0;
                  addr_q     <= pick ? bus.addr1  : bus.addr0;
                  wdata_q    <= pick ? bus.wdata1 : bus.wdata0;
               end
            end
            ISSUE: cnt <= CNT_W'(MEM_LATENCY - 1);
            WAIT: begin
               if (cnt == '0) begin
                  if (owner) rdata1_q <= bus.mem_rdata;
                  else       rdata0_q <= bus.mem_rdata;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.mem_en    = (state == ISSUE);
      bus.mem_we    = (state == ISSUE) && we_q;
      bus.ack0      = (state == ACK) && !owner;
      bus.ack1      = (state == ACK) && owner;
      bus.busy      = (state != IDLE);
      bus.grant     = 2'b00;
      if (state != IDLE) bus.grant = owner ? 2'b10 : 2'b01;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.rdata0    = rdata0_q;
      bus.rdata1    = rdata1_q;
   end

endmodule
